fxp_frame_accum: RTL and testbench
==================================

Name: fxp_frame_accum

Overview:
- Streaming fixed-point frame accumulator. Sums up to LEN signed WII.WIF samples per frame and converts the sum to WOI.WOF, with rounding and saturation.
- Sits directly upstream of fxp2float / fxp2float_pipe. It produces the fixed-point operand those converters consume.
- Uses a valid/ready handshake on both sides, so it can stall behind a busy consumer.

Parameters:
- WII, 16, integer bits of input, including sign.
- WIF, 16, fraction bits of input.
- WOI, 16, integer bits of output, including sign.
- WOF, 16, fraction bits of output.
- ROUND, 1, 1 = round-half-up when fraction bits are dropped; 0 = truncate toward minus infinity.
- LEN, 4, maximum samples per frame; must be ≥1.

Ports:
- rstn  in  1  synchronous, active-low reset
- clk  in  1  clock
- i_valid  in  1  input sample valid
- i_ready  out  1  block accepts input sample this cycle
- i_data  in  WII+WIF  signed input sample
- i_last  in  1  sample is last of frame (early frame end)
- o_valid  out  1  result valid
- o_ready  in  1  consumer accepts result
- o_data  out  WOI+WOF  signed frame sum, WOI.WOF
- o_overflow  out  1  o_data was saturated
- o_count  out  $clog2(LEN+1)  samples summed into o_data

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock clk.
- Reset (rstn=0 at posedge):
  - Outputs: o_valid=0, o_data=0, o_overflow=0, o_count=0.
  - Internal: accumulator=0, sample counter=0. Any partial frame is discarded.
- i_ready is combinational: i_ready = rstn & (~o_valid | o_ready).
- Transfers:
  - Input accept: i_valid & i_ready.
  - Output accept: o_valid & o_ready.
- Accumulator: signed, width WII+$clog2(LEN)+1 integer bits and WIF fraction bits, sign-extended from i_data. It never overflows internally.
- On input accept, the sample is summed in. The frame ends if counter+1==LEN or i_last=1 (whichever comes first; i_last with counter+1==LEN is one frame end). At frame end, at the same posedge:
  - Convert (accumulator + sample) and register it into o_data, o_overflow, o_count=counter+1.
  - Set o_valid=1.
  - Clear accumulator and counter to 0.
- Otherwise: accumulator += sample, counter += 1.
- Latency: o_valid rises the cycle after the final sample is accepted.
- Output handshake:
  - Output accept with no new frame end in the same cycle: o_valid goes 0.
  - Output accept and frame end in the same cycle: the new result loads and o_valid stays 1. This gives full throughput; LEN=1 gives one result per cycle.
- While o_valid=1 and o_ready=0:
  - o_data, o_overflow and o_count hold stable.
  - i_ready=0; no samples are accepted or lost.
- A partial frame persists across output stalls and across idle cycles (i_valid=0).
- Conversion from accumulator (WIF fraction) to output (WOF fraction):
  - WOF ≥ WIF: shift left by WOF-WIF, zero fill.
  - WOF < WIF, ROUND=1: add 2^(WIF-WOF-1) in accumulator LSBs, then drop WIF-WOF LSBs (round-half-up, ties toward +inf).
  - WOF < WIF, ROUND=0: drop the LSBs (floor).
- Saturation: if the result exceeds the output range, clamp and set o_overflow=1; otherwise o_overflow=0.
  - Maximum: 2^(WOI-1)-2^-WOF, all ones except the sign bit.
  - Minimum: -2^(WOI-1), sign bit only.
- Internal state: a single HOLD flag (o_valid) plus the counter. The states are ACC (o_valid=0) and HOLD (o_valid=1). ACC→HOLD on frame end. HOLD→ACC on output accept without frame end. HOLD→HOLD on output accept with frame end.
- i_data, i_last are ignored when i_valid=0. o_ready is ignored when o_valid=0.

Test Plan:
1. Defaults; i_data 0x00010000, 0x00020000, 0x00030000, 0x00040000 back-to-back, o_ready=1 -> one cycle after the 4th accept: o_valid=1, o_data=0x000A0000, o_count=4, o_overflow=0.
2. Saturation (defaults):
   - Four samples 0x7FFF0000 -> o_data=0x7FFFFFFF, o_overflow=1.
   - Four samples 0x80000000 -> o_data=0x80000000, o_overflow=1.
3. Early end: 0x00018000 then 0xFFFFC000 with i_last=1 -> o_data=0x00014000 (1.25), o_count=2. The next frame starts from a zero accumulator.
4. Backpressure: complete a frame, hold o_ready=0 for 5 cycles while i_valid=1 -> i_ready=0 and o_* stable all 5 cycles. Then set o_ready=1 -> output accept and input accept in the same cycle, and the next frame sum includes that sample.
5. Rounding, instance WOF=8, LEN=1:
   - i_data 0x00000080: ROUND=1 -> o_data=0x000001; ROUND=0 -> 0x000000.
   - i_data 0xFFFFFF80: ROUND=1 -> 0x000000; ROUND=0 -> 0xFFFFFF.
6. Reset mid-frame: accept two samples 0x00050000, pulse rstn=0 for one cycle, then send four samples 0x00010000 -> o_data=0x00040000, o_count=4. Also: with LEN=1, i_valid=1 and o_ready=1 continuously -> o_valid stays 1 and o_data updates every cycle.

Source files
------------

// File: rtl/fxp_frame_accum.sv
// Streaming fixed-point frame accumulator: sums up to LEN signed
// WII.WIF samples per frame and emits a rounded, saturated WOI.WOF sum.
//
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   i_valid     input sample valid
//   i_ready     block can take a sample this cycle
//   i_data      signed WII.WIF sample
//   i_last      sample closes the frame early
//   o_valid     frame result valid (held until o_ready)
//   o_ready     consumer takes the result
//   o_data      signed WOI.WOF frame sum
//   o_overflow  o_data was clamped to the output range
//   o_count     number of samples summed into o_data
module fxp_frame_accum #(
    parameter int WII   = 16,
    parameter int WIF   = 16,
    parameter int WOI   = 16,
    parameter int WOF   = 16,
    parameter int ROUND = 1,
    parameter int LEN   = 4
) (
    input  logic                       rstn,
    input  logic                       clk,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [WII+WIF-1:0]         i_data,
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [WOI+WOF-1:0]         o_data,
    output logic                       o_overflow,
    output logic [$clog2(LEN+1)-1:0]   o_count
);

    localparam int IW = WII + WIF;
    localparam int OW = WOI + WOF;
    localparam int CW = $clog2(LEN + 1);
    // Enough integer headroom that LEN full-scale samples never wrap.
    localparam int AW = WII + $clog2(LEN) + 1 + WIF;
    localparam int SH = (WOF >= WIF) ? WOF - WIF : 0;
    localparam int DR = (WOF < WIF) ? WIF - WOF : 0;
    // Working width for the conversion: room for the left shift,
    // the rounding carry, and the output range plus a guard bit.
    localparam int XA = AW + SH + 1;
    localparam int XW = ((XA > OW) ? XA : OW) + 1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [CW-1:0]        cnt;
    logic [CW:0]          cnt_inc;
    logic                 in_acc;
    logic                 out_acc;
    logic                 fend;

    logic signed [XW-1:0] sum_x;
    logic signed [XW-1:0] scaled;
    logic signed [XW-1:0] max_x;
    logic signed [XW-1:0] min_x;
    logic [OW-1:0]        conv_data;
    logic                 conv_ovf;

    assign i_ready = rstn & (~o_valid | o_ready);
    assign in_acc  = i_valid & i_ready;
    assign out_acc = o_valid & o_ready;

    assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
    assign fend    = i_last | (cnt_inc == (CW+1)'(LEN));

    assign sum   = acc + {{(AW-IW){i_data[IW-1]}}, i_data};
    assign sum_x = {{(XW-AW){sum[AW-1]}}, sum};

    generate
        if (DR > 0) begin : g_drop
            localparam logic [XW-1:0] HALF =
                (ROUND != 0) ? (XW'(1) << (DR - 1)) : XW'(0);
            logic signed [XW-1:0] rnd;
            // XW leaves at least one spare bit, so the add cannot wrap;
            // the arithmetic shift then floors toward minus infinity.
            assign rnd    = sum_x + HALF;
            assign scaled = rnd >>> DR;
        end else begin : g_shift
            assign scaled = sum_x <<< SH;
        end
    endgenerate

    assign max_x = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    assign min_x = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        conv_data = scaled[OW-1:0];
        conv_ovf  = 1'b0;
        if (scaled > max_x) begin
            conv_data = max_x[OW-1:0];
            conv_ovf  = 1'b1;
        end else if (scaled < min_x) begin
            conv_data = min_x[OW-1:0];
            conv_ovf  = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a frame end always (re)loads the result, which
    // lets a drained result be replaced in the same cycle.
    always_comb begin
        state_nx = state;
        if (in_acc && fend) begin
            state_nx = HOLD;
        end else if (out_acc) begin
            state_nx = ACC;
        end
    end

    // Outputs
    always_comb begin
        o_valid = (state == HOLD);
    end

    // Accumulator, counter and result registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc        <= '0;
            cnt        <= '0;
            o_data     <= '0;
            o_overflow <= 1'b0;
            o_count    <= '0;
        end else if (in_acc) begin
            if (fend) begin
                acc        <= '0;
                cnt        <= '0;
                o_data     <= conv_data;
                o_overflow <= conv_ovf;
                o_count    <= cnt_inc[CW-1:0];
            end else begin
                acc <= sum;
                cnt <= cnt_inc[CW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fxp_frame_accum.sv
// Scoreboard bench for fxp_frame_accum: a default instance plus two
// LEN=1, WOF=8 instances exercising both rounding modes.
module tb_fxp_frame_accum;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    always #5 clk = ~clk;

    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] i_data = '0;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [31:0] o_data;
    logic        o_overflow;
    logic [2:0]  o_count;

    logic        r_valid = 1'b0;
    logic        r_ready = 1'b1;
    logic [31:0] r_data = '0;
    logic        r_last = 1'b0;
    logic        r1_iready, r0_iready;
    logic        r1_valid, r0_valid;
    logic [23:0] r1_data, r0_data;
    logic        r1_ovf, r0_ovf;
    logic [0:0]  r1_cnt, r0_cnt;

    fxp_frame_accum u_dut (
        .rstn(rstn), .clk(clk),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .i_last(i_last),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .o_overflow(o_overflow),
        .o_count(o_count)
    );

    fxp_frame_accum #(.WOF(8), .ROUND(1), .LEN(1)) u_r1 (
        .rstn(rstn), .clk(clk),
        .i_valid(r_valid), .i_ready(r1_iready),
        .i_data(r_data), .i_last(r_last),
        .o_valid(r1_valid), .o_ready(r_ready),
        .o_data(r1_data), .o_overflow(r1_ovf),
        .o_count(r1_cnt)
    );

    fxp_frame_accum #(.WOF(8), .ROUND(0), .LEN(1)) u_r0 (
        .rstn(rstn), .clk(clk),
        .i_valid(r_valid), .i_ready(r0_iready),
        .i_data(r_data), .i_last(r_last),
        .o_valid(r0_valid), .o_ready(r_ready),
        .o_data(r0_data), .o_overflow(r0_ovf),
        .o_count(r0_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        int          cnt;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] partq[$];
    logic [24:0] rq1[$];
    logic [24:0] rq0[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          rmode = 0;

    function automatic void chk(string nm, longint got, longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endfunction

    // Exact real-valued rescale: values are integers in units of
    // 2^-wif in, 2^-wof out; >>> on longint is a floor.
    function automatic longint conv(longint s, int wif, int wof,
                                    int woi, int rnd, output bit ovf);
        longint v, mx, mn;
        if (wof >= wif) begin
            v = s <<< (wof - wif);
        end else begin
            v = s;
            if (rnd != 0) v = v + (longint'(1) <<< (wif - wof - 1));
            v = v >>> (wif - wof);
        end
        mx = (longint'(1) <<< (woi + wof - 1)) - 1;
        mn = -(longint'(1) <<< (woi + wof - 1));
        ovf = 1'b0;
        if (v > mx) begin
            v = mx;
            ovf = 1'b1;
        end else if (v < mn) begin
            v = mn;
            ovf = 1'b1;
        end
        return v;
    endfunction

    function automatic void model_accept(logic [31:0] d, logic l);
        longint s;
        bit     ov;
        exp_t   e;
        partq.push_back(d);
        if (partq.size() == LEN || l) begin
            s = 0;
            foreach (partq[k]) s += longint'(signed'(partq[k]));
            e.data = 32'(conv(s, 16, 16, 16, 1, ov));
            e.ovf  = ov;
            e.cnt  = partq.size();
            sbq.push_back(e);
            partq.delete();
        end
    endfunction

    function automatic logic pick_ready();
        if (rmode == 0) return 1'b1;
        if (rmode == 2) return 1'b0;
        return ($urandom % 3) != 0;
    endfunction

    function automatic logic [31:0] rnd_sample();
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'h7FFF_0000 | 32'($urandom % 65536);
            default: return 32'($urandom_range(0, 32'h01FF_FFFF))
                            - 32'h0100_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rstn && o_valid && o_ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h expected none",
                         o_data);
            end else begin
                e = sbq.pop_front();
                chk("o_data", o_data, e.data);
                chk("o_overflow", o_overflow, e.ovf);
                chk("o_count", o_count, e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        logic [24:0] e;
        if (rstn && r_ready && r1_valid) begin
            if (rq1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL r1_unexpected: got 0x%0h expected none",
                         r1_data);
            end else begin
                e = rq1.pop_front();
                chk("r1_data", {r1_ovf, r1_data}, e);
                chk("r1_count", r1_cnt, 1);
            end
        end
        if (rstn && r_ready && r0_valid) begin
            if (rq0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL r0_unexpected: got 0x%0h expected none",
                         r0_data);
            end else begin
                e = rq0.pop_front();
                chk("r0_data", {r0_ovf, r0_data}, e);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        forever begin
            o_ready = pick_ready();
            @(negedge clk);
            if (i_ready) break;
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got i_ready=0 expected 1");
                i_valid = 1'b0;
                return;
            end
        end
        model_accept(d, l);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = $urandom;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        o_ready = pick_ready();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rmode = 0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (sbq.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic rstream(input logic [31:0] d, input bit first);
        bit ov;
        logic [23:0] v;
        r_valid = 1'b1;
        r_data  = d;
        @(negedge clk);
        chk("r_i_ready", {r1_iready, r0_iready}, 2'b11);
        if (!first) chk("r1_valid_stream", r1_valid, 1);
        v = 24'(conv(longint'(signed'(d)), 16, 8, 16, 1, ov));
        rq1.push_back({ov, v});
        v = 24'(conv(longint'(signed'(d)), 16, 8, 16, 0, ov));
        rq0.push_back({ov, v});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_overflow", o_overflow, 0);
        chk("rst_o_count", o_count, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_r1_valid", {r1_valid, r0_valid}, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // basic frame and latency
        rmode = 0;
        send(32'h0001_0000, 1'b0);
        send(32'h0002_0000, 1'b0);
        send(32'h0003_0000, 1'b0);
        chk("pre_latency_o_valid", o_valid, 0);
        send(32'h0004_0000, 1'b0);
        chk("latency_o_valid", o_valid, 1);
        drain();

        // saturation both ways
        repeat (4) send(32'h7FFF_0000, 1'b0);
        drain();
        repeat (4) send(32'h8000_0000, 1'b0);
        drain();

        // early end, then a fresh frame
        send(32'h0001_8000, 1'b0);
        send(32'hFFFF_C000, 1'b1);
        repeat (4) send(32'h0001_0000, 1'b0);
        drain();

        // backpressure
        rmode = 2;
        send(32'h0000_1000, 1'b0);
        send(32'h0000_2000, 1'b0);
        send(32'h0000_3000, 1'b0);
        send(32'h0000_4000, 1'b0);
        x = 32'h0003_0000;
        i_valid = 1'b1;
        i_data  = x;
        o_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_i_ready", i_ready, 0);
            chk("stall_o_valid", o_valid, 1);
            if (sbq.size() > 0) begin
                chk("stall_o_data", o_data, sbq[0].data);
                chk("stall_o_count", o_count, sbq[0].cnt);
            end
            @(posedge clk);
            #1;
        end
        rmode = 0;
        send(x, 1'b0);
        send(32'h0001_0000, 1'b0);
        send(32'h0001_0000, 1'b0);
        send(32'h0001_0000, 1'b0);
        drain();

        // reset mid-frame
        send(32'h0005_0000, 1'b0);
        send(32'h0005_0000, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        partq.delete();
        @(negedge clk);
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_count", o_count, 0);
        @(posedge clk);
        #1;
        repeat (4) send(32'h0001_0000, 1'b0);
        drain();

        // rounding and LEN=1 full throughput
        rstream(32'h0000_0080, 1'b1);
        rstream(32'hFFFF_FF80, 1'b0);
        rstream(32'h7FFF_FF80, 1'b0);
        for (int i = 0; i < 20; i++) rstream($urandom, 1'b0);
        r_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("round_q_empty", rq1.size() + rq0.size(), 0);

        // randomized frames with random backpressure and gaps
        rmode = 1;
        for (int i = 0; i < 80; i++) begin
            send(rnd_sample(), ($urandom % 5) == 0);
            if (($urandom % 4) == 0) idle();
        end
        send(rnd_sample(), 1'b1);
        drain();
        chk("partial_empty", partq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
